// File: rtl/down_counter_timer.sv
// Prescaled down-counter timer with IDLE/RUN/PAUSE control and a one-cycle done pulse.
// Optional macro AUTO_RELOAD_EN: the terminal tick reloads the start value and the count keeps running.
module down_counter_timer #(
   parameter int WIDTH    = 3,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             enable,
   input  logic             abort,
   output logic [WIDTH-1:0] salida,
   output logic             busy,
   output logic             done,
   output logic [1:0]       dbg_state_o
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;

   // Handshake: start is a level sampled on an edge only while IDLE with abort low;
   // done is a single-cycle registered pulse, busy is high for the whole RUN/PAUSE span.

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      presc_d = presc_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_d = reload_q;
`endif
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               if (load_val != '0) begin
                  state_d = RUN;
                  cnt_d   = load_val;
                  presc_d = '0;
                  busy_d  = 1'b1;
`ifdef AUTO_RELOAD_EN
                  reload_d = load_val;
`endif
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN, PAUSE: begin
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
               presc_d = '0;
               busy_d  = 1'b0;
            end else if (!enable) begin
               state_d = PAUSE;
            end else begin
               // The resume edge out of PAUSE counts like any RUN edge.
               state_d = RUN;
               if (presc_q == PS_LAST) begin
                  presc_d = '0;
                  if (cnt_q <= WIDTH'(1)) begin
                     done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                     cnt_d  = reload_q;
`else
                     cnt_d   = '0;
                     busy_d  = 1'b0;
                     state_d = IDLE;
`endif
                  end else begin
                     cnt_d = cnt_q - WIDTH'(1);
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            presc_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         presc_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef AUTO_RELOAD_EN
         reload_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         presc_q <= presc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef AUTO_RELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   assign salida      = cnt_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: vector table on a PRESCALE=1 instance, hand sequences
// for prescale/pause on a PRESCALE=2 instance and for asynchronous reset.
module tb_down_counter_timer;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;

   logic       clk = 1'b0;
   logic       reset;
   logic       start1, en1, ab1, start2, en2, ab2;
   logic [2:0] lv1, lv2;
   logic [2:0] sal1, sal2;
   logic       busy1, busy2, done1, done2;
   logic [1:0] st1, st2;

   int n_checks = 0;
   int n_fail   = 0;
   logic [6:0] exp_q[$];

   always #5 clk = ~clk;

   down_counter_timer #(.WIDTH(3), .PRESCALE(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .load_val(lv1), .enable(en1),
      .abort(ab1), .salida(sal1), .busy(busy1), .done(done1), .dbg_state_o(st1)
   );

   down_counter_timer #(.WIDTH(3), .PRESCALE(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .load_val(lv2), .enable(en2),
      .abort(ab2), .salida(sal2), .busy(busy2), .done(done2), .dbg_state_o(st2)
   );

   typedef struct {
      logic       st;
      logic [2:0] lv;
      logic       en;
      logic       ab;
      logic [1:0] xs;
      logic [2:0] xsal;
      logic       xb;
      logic       xd;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t v(input logic st, input logic [2:0] lv, input logic en,
                              input logic ab, input logic [1:0] xs, input logic [2:0] xsal,
                              input logic xb, input logic xd);
      vec_t r;
      r.st = st; r.lv = lv; r.en = en; r.ab = ab;
      r.xs = xs; r.xsal = xsal; r.xb = xb; r.xd = xd;
      return r;
   endfunction

   function automatic logic [6:0] e(input logic [1:0] s, input logic [2:0] sal,
                                    input logic b, input logic d);
      return {s, sal, b, d};
   endfunction

   task automatic check(input bit which, input string name);
      logic [6:0] exp, act;
      exp = exp_q.pop_front();
      act = which ? {st2, sal2, busy2, done2} : {st1, sal1, busy1, done1};
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got state=%0d salida=%0d busy=%0b done=%0b, expected state=%0d salida=%0d busy=%0b done=%0b",
                  name, act[6:5], act[4:2], act[1], act[0], exp[6:5], exp[4:2], exp[1], exp[0]);
      end
   endtask

   task automatic step(input bit which, input logic st, input logic [2:0] lv, input logic en,
                       input logic ab, input logic [6:0] exp, input string name);
      if (!which) begin
         start1 = st; lv1 = lv; en1 = en; ab1 = ab;
      end else begin
         start2 = st; lv2 = lv; en2 = en; ab2 = ab;
      end
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      check(which, name);
   endtask

   initial begin
      reset  = 1'b0;
      start1 = 1'b1; lv1 = 3'd5; en1 = 1'b1; ab1 = 1'b0;
      start2 = 1'b1; lv2 = 3'd5; en2 = 1'b1; ab2 = 1'b0;

`ifdef AUTO_RELOAD_EN
      vt.push_back(v(0, 0, 1, 0, S_IDLE, 0, 0, 0));
      vt.push_back(v(1, 2, 1, 0, S_RUN,  2, 1, 0));
      vt.push_back(v(0, 0, 1, 0, S_RUN,  1, 1, 0));
      vt.push_back(v(1, 6, 1, 0, S_RUN,  2, 1, 1));
      vt.push_back(v(0, 0, 1, 0, S_RUN,  1, 1, 0));
      vt.push_back(v(0, 0, 1, 0, S_RUN,  2, 1, 1));
      vt.push_back(v(0, 0, 1, 0, S_RUN,  1, 1, 0));
      vt.push_back(v(0, 0, 1, 1, S_IDLE, 0, 0, 0));
      vt.push_back(v(0, 0, 1, 0, S_IDLE, 0, 0, 0));
      vt.push_back(v(1, 0, 1, 0, S_IDLE, 0, 0, 1));
      vt.push_back(v(0, 0, 1, 0, S_IDLE, 0, 0, 0));
`else
      vt.push_back(v(0, 0, 1, 0, S_IDLE, 0, 0, 0));
      vt.push_back(v(1, 5, 1, 0, S_RUN,  5, 1, 0));
      vt.push_back(v(0, 0, 1, 0, S_RUN,  4, 1, 0));
      vt.push_back(v(0, 0, 1, 0, S_RUN,  3, 1, 0));
      vt.push_back(v(0, 0, 1, 0, S_RUN,  2, 1, 0));
      vt.push_back(v(0, 0, 1, 0, S_RUN,  1, 1, 0));
      vt.push_back(v(0, 0, 1, 0, S_IDLE, 0, 0, 1));
      vt.push_back(v(0, 0, 1, 0, S_IDLE, 0, 0, 0));
      vt.push_back(v(1, 0, 1, 0, S_IDLE, 0, 0, 1));
      vt.push_back(v(0, 0, 1, 0, S_IDLE, 0, 0, 0));
      vt.push_back(v(1, 4, 1, 0, S_RUN,  4, 1, 0));
      vt.push_back(v(0, 0, 1, 0, S_RUN,  3, 1, 0));
      vt.push_back(v(0, 0, 1, 0, S_RUN,  2, 1, 0));
      vt.push_back(v(1, 7, 0, 0, S_PAUSE, 2, 1, 0));
      vt.push_back(v(1, 7, 0, 0, S_PAUSE, 2, 1, 0));
      vt.push_back(v(0, 0, 0, 0, S_PAUSE, 2, 1, 0));
      vt.push_back(v(0, 0, 0, 0, S_PAUSE, 2, 1, 0));
      vt.push_back(v(0, 0, 1, 0, S_RUN,  1, 1, 0));
      vt.push_back(v(0, 0, 1, 0, S_IDLE, 0, 0, 1));
      vt.push_back(v(0, 0, 1, 0, S_IDLE, 0, 0, 0));
      vt.push_back(v(1, 6, 1, 0, S_RUN,  6, 1, 0));
      vt.push_back(v(0, 0, 1, 0, S_RUN,  5, 1, 0));
      vt.push_back(v(0, 0, 1, 0, S_RUN,  4, 1, 0));
      vt.push_back(v(0, 0, 1, 0, S_RUN,  3, 1, 0));
      vt.push_back(v(0, 0, 1, 0, S_RUN,  2, 1, 0));
      vt.push_back(v(1, 5, 1, 1, S_IDLE, 0, 0, 0));
      vt.push_back(v(0, 0, 1, 0, S_IDLE, 0, 0, 0));
      vt.push_back(v(1, 3, 1, 0, S_RUN,  3, 1, 0));
      vt.push_back(v(0, 0, 0, 0, S_PAUSE, 3, 1, 0));
      vt.push_back(v(0, 0, 0, 1, S_IDLE, 0, 0, 0));
      vt.push_back(v(0, 0, 1, 0, S_IDLE, 0, 0, 0));
      vt.push_back(v(1, 1, 1, 0, S_RUN,  1, 1, 0));
      vt.push_back(v(0, 0, 1, 0, S_IDLE, 0, 0, 1));
      vt.push_back(v(0, 0, 1, 0, S_IDLE, 0, 0, 0));
`endif

      // Reset held across edges with start high: nothing may load.
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(e(S_IDLE, 0, 0, 0));
      check(0, "reset_dut1");
      exp_q.push_back(e(S_IDLE, 0, 0, 0));
      check(1, "reset_dut2");
      start1 = 1'b0; start2 = 1'b0;
      reset  = 1'b1;

      foreach (vt[i])
         step(0, vt[i].st, vt[i].lv, vt[i].en, vt[i].ab,
              e(vt[i].xs, vt[i].xsal, vt[i].xb, vt[i].xd), $sformatf("vec%0d", i));

      // PRESCALE=2, load 3: a decrement every second edge, terminal at edge k+6.
      step(1, 1, 3, 1, 0, e(S_RUN, 3, 1, 0), "p2_start");
      step(1, 0, 0, 1, 0, e(S_RUN, 3, 1, 0), "p2_k1");
      step(1, 0, 0, 1, 0, e(S_RUN, 2, 1, 0), "p2_k2");
      step(1, 0, 0, 1, 0, e(S_RUN, 2, 1, 0), "p2_k3");
      step(1, 0, 0, 1, 0, e(S_RUN, 1, 1, 0), "p2_k4");
      step(1, 0, 0, 1, 0, e(S_RUN, 1, 1, 0), "p2_k5");
`ifdef AUTO_RELOAD_EN
      step(1, 0, 0, 1, 0, e(S_RUN, 3, 1, 1), "p2_k6");
      step(1, 0, 0, 1, 0, e(S_RUN, 3, 1, 0), "p2_k7");
      step(1, 0, 0, 1, 1, e(S_IDLE, 0, 0, 0), "p2_abort");
`else
      step(1, 0, 0, 1, 0, e(S_IDLE, 0, 0, 1), "p2_k6");
      step(1, 0, 0, 1, 0, e(S_IDLE, 0, 0, 0), "p2_k7");
`endif

      // Pause with the prescaler mid-period: it must resume from its held value.
      step(1, 1, 2, 1, 0, e(S_RUN, 2, 1, 0), "p2p_start");
      step(1, 0, 0, 1, 0, e(S_RUN, 2, 1, 0), "p2p_half");
      step(1, 0, 0, 0, 0, e(S_PAUSE, 2, 1, 0), "p2p_pause0");
      step(1, 1, 5, 0, 0, e(S_PAUSE, 2, 1, 0), "p2p_pause1");
      step(1, 0, 0, 1, 0, e(S_RUN, 1, 1, 0), "p2p_resume");
      step(1, 0, 0, 1, 0, e(S_RUN, 1, 1, 0), "p2p_half2");
`ifdef AUTO_RELOAD_EN
      step(1, 0, 0, 1, 0, e(S_RUN, 2, 1, 1), "p2p_term");
      step(1, 0, 0, 1, 1, e(S_IDLE, 0, 0, 0), "p2p_abort");
`else
      step(1, 0, 0, 1, 0, e(S_IDLE, 0, 0, 1), "p2p_term");
      step(1, 0, 0, 1, 0, e(S_IDLE, 0, 0, 0), "p2p_after");
`endif

      // Reset mid-count takes effect without a clock edge and leaves no done pulse.
      step(0, 1, 5, 1, 0, e(S_RUN, 5, 1, 0), "rst_start");
      step(0, 0, 0, 1, 0, e(S_RUN, 4, 1, 0), "rst_run");
      #2;
      reset = 1'b0;
      #1;
      exp_q.push_back(e(S_IDLE, 0, 0, 0));
      check(0, "rst_async");
      start1 = 1'b1; lv1 = 3'd6;
      @(posedge clk);
      #1;
      exp_q.push_back(e(S_IDLE, 0, 0, 0));
      check(0, "rst_hold_start");
      reset = 1'b1;
      step(0, 0, 0, 1, 0, e(S_IDLE, 0, 0, 0), "rst_no_done");
      step(0, 1, 2, 1, 0, e(S_RUN, 2, 1, 0), "rst_restart");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/down_counter_timer.md
DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 Parameter: WIDTH, default 3, width of the count and load value.
REQ-002 Parameter: PRESCALE, default 1, clock cycles per decrement; legal values are 1 or more.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 Port: start  input  1  load load_val and begin counting down; sampled only in IDLE.
REQ-006 Port: load_val  input  WIDTH  initial count, captured on an accepted start.
REQ-007 Port: enable  input  1  1 = count, 0 = pause (hold all state).
REQ-008 Port: abort  input  1  cancel the current count.
REQ-009 Port: salida  output  WIDTH  current count value (registered).
REQ-010 Port: busy  output  1  high while the count is in progress (RUN or PAUSE).
REQ-011 Port: done  output  1  one-cycle pulse when the count reaches terminal.

Function
REQ-012 The FSM SHALL have three states (IDLE, RUN, PAUSE) plus an internal prescale counter of ceil(log2(PRESCALE)) bits, minimum 1.
REQ-013 IDLE, start=1, load_val=N≠0, sampled at edge k: salida=N and busy=1 after edge k; prescale counter=0; state → RUN.
REQ-014 IDLE, start=1, load_val=0: done=1 for exactly the cycle after the edge; busy stays 0; state stays IDLE.
REQ-015 RUN, enable=1: the prescale counter increments each edge; on reaching PRESCALE-1 it wraps to 0 and salida decrements by 1 on that edge.
REQ-016 Latency: with enable held high, salida=0 and done=1 occur at edge k+N·PRESCALE; busy falls on the same edge; state → IDLE.
REQ-017 RUN, enable=0: state → PAUSE; salida and the prescale counter hold.
REQ-018 PAUSE, enable=1: state → RUN; the prescale counter resumes from its held value.
REQ-019 The counter SHALL never wrap below 0; salida=0 in IDLE after a completed or aborted count.
REQ-020 abort=1 in RUN or PAUSE: salida←0, busy←0, state→IDLE on the next edge; no done pulse.
REQ-021 abort has priority over start and enable when they coincide.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 done SHALL be high for exactly one cycle per terminal event and never high in PAUSE.

Reset
REQ-024 reset=0 SHALL immediately and asynchronously force: salida=0, busy=0, done=0, state=IDLE, prescale counter=0, reload register=0.
REQ-025 start SHALL NOT be accepted on any edge where reset=0; reset mid-count SHALL discard the count without a done pulse.

Configuration
REQ-026 Macro AUTO_RELOAD_EN: when defined, an accepted start also stores load_val in an internal reload register.
REQ-027 With AUTO_RELOAD_EN, on the terminal tick in RUN, salida loads the reload register instead of 0, done pulses, busy stays 1, and the state stays RUN; only abort or reset stop counting.
REQ-028 Without AUTO_RELOAD_EN, there is no reload register and REQ-016 applies.

Verification
REQ-029 WIDTH=3, PRESCALE=1, start with load_val=5 -> salida 5,4,3,2,1,0 on consecutive edges; done=1 and busy=0 at edge k+5.
REQ-030 PRESCALE=2, load_val=3 -> salida decrements every 2 edges; done at edge k+6, for one cycle.
REQ-031 load_val=0 -> done=1 for one cycle after the start edge; busy never asserts.
REQ-032 load_val=4, enable low for 4 cycles at salida=2 -> salida holds at 2; done delayed to edge k+8; start during the pause is ignored.
REQ-033 abort at salida=2 (and separately, reset=0 mid-count) -> salida=0 and busy=0 (reset: immediately, without waiting for clk); no done pulse.
REQ-034 With AUTO_RELOAD_EN, load_val=2, PRESCALE=1 -> salida 2,1,2,1...; done every 2 cycles; busy stays 1 until abort.
